// File: rtl/timer_core.sv
// 48-bit free-running/periodic timer with compare match, sticky match flag and
// level interrupt, exposed as a 6-register MMIO slot.
module timer_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam logic [4:0] A_CNT_LO = 5'd0;
    localparam logic [4:0] A_CNT_HI = 5'd1;
    localparam logic [4:0] A_CTRL   = 5'd2;
    localparam logic [4:0] A_CMP_LO = 5'd3;
    localparam logic [4:0] A_CMP_HI = 5'd4;
    localparam logic [4:0] A_STATUS = 5'd5;

    logic [47:0] cnt_q, cnt_d;
    logic [47:0] cmp_q, cmp_d;
    logic [15:0] hi_shadow_q, hi_shadow_d;
    logic        go_q, go_d;
    logic        periodic_q, periodic_d;
    logic        irq_en_q, irq_en_d;
    logic        match_q, match_d;

    logic bus_wr, bus_rd, hit, clr;

    assign bus_wr = cs & write;
    assign bus_rd = cs & read;
    // Zero compare value disables matching altogether.
    assign hit    = go_q & (cmp_q != 48'd0) & (cnt_q == cmp_q);
    assign clr    = bus_wr & (addr == A_CTRL) & wr_data[1];

    always_comb begin
        cnt_d       = cnt_q;
        cmp_d       = cmp_q;
        hi_shadow_d = hi_shadow_q;
        go_d        = go_q;
        periodic_d  = periodic_q;
        irq_en_d    = irq_en_q;
        match_d     = match_q;

        if (go_q) begin
            if (hit && periodic_q) cnt_d = 48'd0;
            else                   cnt_d = cnt_q + 48'd1;
        end
        if (clr) cnt_d = 48'd0;

        // Latch the upper half on a low-half read so a following CNT_HI read is coherent.
        if (bus_rd && addr == A_CNT_LO) hi_shadow_d = cnt_q[47:32];

        if (bus_wr) begin
            case (addr)
                A_CTRL: begin
                    go_d       = wr_data[0];
                    periodic_d = wr_data[2];
                    irq_en_d   = wr_data[3];
                end
                A_CMP_LO: cmp_d[31:0]  = wr_data;
                A_CMP_HI: cmp_d[47:32] = wr_data[15:0];
                A_STATUS: if (wr_data[0]) match_d = 1'b0;
                default: ;
            endcase
        end
        // A fresh match outranks a same-cycle W1C.
        if (hit) match_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            cmp_q       <= '0;
            hi_shadow_q <= '0;
            go_q        <= 1'b0;
            periodic_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cmp_q       <= cmp_d;
            hi_shadow_q <= hi_shadow_d;
            go_q        <= go_d;
            periodic_q  <= periodic_d;
            irq_en_q    <= irq_en_d;
            match_q     <= match_d;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            A_CNT_LO: rd_data = cnt_q[31:0];
            A_CNT_HI: rd_data = {16'd0, hi_shadow_q};
            A_CTRL:   rd_data = {28'd0, irq_en_q, periodic_q, 1'b0, go_q};
            A_CMP_LO: rd_data = cmp_q[31:0];
            A_CMP_HI: rd_data = {16'd0, cmp_q[47:32]};
            A_STATUS: rd_data = {31'd0, match_q};
            default:  rd_data = 32'd0;
        endcase
    end

    assign irq = match_q & irq_en_q;

endmodule

// File: tb/tb_timer_core.sv
// Scoreboarded bench for timer_core: the driver pushes expected read data/irq
// from a register-level model; a negedge monitor pops on every cs&&read.
module tb_timer_core;

    logic        clk = 1'b0;
    logic        reset, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        irq;

    timer_core dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state, advanced once per clock from the register-map rules.
    longint m_cnt, m_cmp;
    int     m_hi;
    bit     m_go, m_per, m_ien, m_flag;
    localparam longint MASK48 = 64'h0000_FFFF_FFFF_FFFF;

    function automatic logic [31:0] rd_exp(input logic [4:0] a);
        case (a)
            5'd0: return m_cnt[31:0];
            5'd1: return m_hi;
            5'd2: return {28'd0, m_ien, m_per, 1'b0, m_go};
            5'd3: return m_cmp[31:0];
            5'd4: return {16'd0, m_cmp[47:32]};
            5'd5: return {31'd0, m_flag};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit     hit, wr;
        longint nc;
        if (reset) begin
            m_cnt = 0; m_cmp = 0; m_hi = 0;
            m_go = 0; m_per = 0; m_ien = 0; m_flag = 0;
            return;
        end
        hit = m_go && m_cmp != 0 && m_cnt == m_cmp;
        wr  = cs && write;
        nc  = m_cnt;
        if (m_go) nc = (hit && m_per) ? 0 : ((m_cnt + 1) & MASK48);
        if (wr && addr == 2 && wr_data[1]) nc = 0;
        if (cs && read && addr == 0) m_hi = int'(m_cnt[47:32]);
        if (wr && addr == 5 && wr_data[0]) m_flag = 0;
        if (hit) m_flag = 1;
        if (wr && addr == 2) begin
            m_go = wr_data[0]; m_per = wr_data[2]; m_ien = wr_data[3];
        end
        if (wr && addr == 3) m_cmp = (m_cmp & 64'hFFFF_0000_0000) | longint'(wr_data);
        if (wr && addr == 4) m_cmp = (m_cmp & 64'h0000_FFFF_FFFF) | (longint'(wr_data[15:0]) << 32);
        m_cnt = nc;
    endtask

    // One bus cycle; caller is aligned to posedge+1.
    task automatic bus(input bit rst, input bit c, input bit r, input bit w,
                       input logic [4:0] a, input logic [31:0] d, input string nm);
        reset = rst; cs = c; read = r; write = w; addr = a; wr_data = d;
        if (c && r) sb.push_back('{rd_exp(a), m_flag && m_ien, nm});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(0, 1, 0, 1, a, d, "");
    endtask
    task automatic rd(input logic [4:0] a, input string nm);
        bus(0, 1, 1, 0, a, 32'd0, nm);
    endtask
    task automatic idle();
        bus(0, 0, 0, 0, 5'd0, 32'd0, "");
    endtask

    // Backdoor preload of the counter, mirrored into the model.
    task automatic force_cnt(input longint v);
        force dut.cnt_q = v[47:0];
        #1;
        release dut.cnt_q;
        m_cnt = v;
    endtask

    always @(negedge clk) begin
        if (cs === 1'b1 && read === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: read seen at addr %0d with nothing expected", addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rd_data !== e.rd || irq !== e.irq) begin
                    n_bad++;
                    $display("FAIL %s: addr=%0d rd_data=%h irq=%b, required rd_data=%h irq=%b",
                             e.nm, addr, rd_data, irq, e.rd, e.irq);
                end
            end
        end
    end

    initial begin
        reset = 1; cs = 0; read = 0; write = 0; addr = 0; wr_data = 0;
        m_cnt = 0; m_cmp = 0; m_hi = 0; m_go = 0; m_per = 0; m_ien = 0; m_flag = 0;
        @(posedge clk); #1;
        bus(1, 0, 0, 0, 5'd0, 32'd0, "");
        bus(1, 0, 0, 0, 5'd0, 32'd0, "");
        for (int a = 0; a < 6; a++) rd(5'(a), "reset_state");
        rd(5'd17, "reset_unmapped");

        // Basic count: 10 idle cycles after go.
        wr(2, 32'h1);
        repeat (10) idle();
        rd(0, "count10_lo");
        rd(1, "count10_hi");

        // go+clr mid-count, then a write with cs low.
        for (int i = 0; i < 200 && m_cnt != 100; i++) idle();
        wr(2, 32'h3);
        rd(0, "clr_lo0");
        rd(0, "clr_lo1");
        bus(0, 0, 0, 1, 5'd3, 32'h1234, "");
        bus(0, 0, 0, 1, 5'd2, 32'h0, "");
        rd(3, "cs0_cmp_lo");
        rd(2, "cs0_ctrl");

        // Periodic, cmp=5, irq enabled.
        wr(2, 32'h2);
        wr(3, 32'd5);
        wr(4, 32'd0);
        wr(5, 32'h1);
        wr(2, 32'hF);
        for (int i = 0; i < 14; i++) rd(0, "periodic_cnt");
        rd(5, "periodic_flag");
        rd(2, "periodic_ctrl");

        // One-shot cmp=3; second match after wrap coincides with W1C.
        wr(2, 32'h2);
        wr(5, 32'h1);
        wr(3, 32'd3);
        wr(2, 32'hB);
        for (int i = 0; i < 6; i++) rd(5, "oneshot_flag");
        force_cnt(MASK48 - 2);
        for (int i = 0; i < 20; i++) begin
            if (m_cnt == m_cmp) begin
                wr(5, 32'h1);
                break;
            end
            rd(0, "oneshot_wrap_cnt");
        end
        rd(5, "set_beats_w1c");
        wr(5, 32'h0);
        rd(5, "w1c_zero_noop");
        wr(5, 32'h1);
        rd(5, "w1c_clear");

        // Coherent 48-bit read across the 32-bit boundary.
        wr(2, 32'h2);
        wr(3, 32'd0);
        wr(2, 32'h3);
        force_cnt(64'h0000_FFFF_FFFB);
        for (int i = 0; i < 10; i++) begin
            if (m_cnt[31:0] == 32'hFFFF_FFFF) begin
                rd(0, "boundary_lo");
                break;
            end
            rd(0, "boundary_pre");
        end
        rd(1, "boundary_hi_latched");
        rd(0, "boundary_lo2");
        rd(1, "boundary_hi2");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          r, w, c, rs;
            logic [4:0]  a;
            logic [31:0] d;
            rs = ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 7) != 0);
            r  = $urandom_range(0, 1);
            w  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            d  = $urandom;
            if (a == 3) d = $urandom_range(0, 40);
            if (a == 4) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            if (a == 2) d[1] = ($urandom_range(0, 5) == 0);
            bus(rs, c, r, w, a, d, "random");
        end

        // Reset while running with flag set; concurrent write must lose.
        wr(2, 32'h2);
        wr(3, 32'd10);
        wr(4, 32'd0);
        wr(2, 32'hB);
        for (int i = 0; i < 100 && m_cnt != 50; i++) idle();
        rd(5, "pre_reset_flag");
        bus(1, 1, 0, 1, 5'd2, 32'hF, "");
        for (int a = 0; a < 6; a++) rd(5'(a), "post_reset");
        rd(5'd17, "post_reset_unmapped");
        idle();
        rd(0, "post_reset_stopped");

        repeat (3) idle();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d expected reads never observed, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1);
    end

endmodule
